contador_updown_param: RTL and testbench

CONTADOR_UPDOWN_PARAM -- requirements
Module: contador_updown_param

---
 rtl/contador_updown_param.sv | 114 +++++++++++
 tb/tb_contador_updown_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/contador_updown_param.sv
`default_nettype none
// ============================================================================
//  Module      : contador_updown_param
//  Description : Parameterised up/down modulo counter with synchronous clear,
//                parallel load (clamped to the count range), a combinational
//                terminal-count flag and a registered boundary-event pulse.
//
//  Parameters
//      WIDTH    : counter width in bits (2..16)
//      MODULO   : count range is 0..MODULO-1 (2..2^WIDTH)
//      INIT_TOP : clear value select, 1 -> MODULO-1, 0 -> 0
//
//  Ports
//      clk   in   1      single clock, all state changes on the rising edge
//      clear in   1      synchronous active-high clear (highest priority)
//      en    in   1      count enable, one step per cycle
//      up    in   1      direction, 1 = increment, 0 = decrement
//      load  in   1      synchronous parallel load strobe (beats en)
//      din   in   WIDTH  load value, values above MODULO-1 clamp to MODULO-1
//      out   out  WIDTH  registered count value
//      tc    out  1      en high and out at the bound for the direction
//      evt   out  1      registered pulse, the cycle after a boundary step
//
//  Build option
//      CONTADOR_SAT_EN : when defined the counter saturates at the bounds
//                        instead of wrapping; a blocked step still pulses evt.
//                        The port list is the same in both builds.
//
//  Revision    : 1.0  initial release
// ============================================================================
module contador_updown_param #(
    parameter int WIDTH    = 5,
    parameter int MODULO   = 32,
    parameter int INIT_TOP = 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             evt
);

    // MODULO may equal 2^WIDTH, so the top value is formed in integer
    // arithmetic first and only then narrowed to the counter width.
    localparam int             c_top_int = MODULO - 1;
    localparam logic [WIDTH-1:0] c_max   = c_top_int[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_init  = (INIT_TOP != 0) ? c_max : '0;

    logic [WIDTH-1:0] r_out;
    logic             r_evt;

    logic             w_at_top;
    logic             w_at_bot;
    logic             w_at_bound;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_bound_next;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_next;
    logic             w_evt_next;

    assign w_at_top   = (r_out == c_max);
    assign w_at_bot   = (r_out == '0);
    assign w_at_bound = up ? w_at_top : w_at_bot;

    // Plain +/-1; the bound cases are replaced below so the result never
    // leaves 0..MODULO-1 even when MODULO is not a power of two.
    assign w_inc = r_out + 1'b1;
    assign w_dec = r_out - 1'b1;

    // Value taken when a step is attempted at the bound.
`ifdef CONTADOR_SAT_EN
    assign w_bound_next = r_out;
`else
    assign w_bound_next = up ? '0 : c_max;
`endif

    assign w_load_val = (din > c_max) ? c_max : din;

    always_comb begin
        w_next     = r_out;
        w_evt_next = 1'b0;
        if (clear) begin
            w_next     = c_init;
            w_evt_next = 1'b0;
        end else if (load) begin
            w_next     = w_load_val;
        end else if (en) begin
            if (w_at_bound) begin
                w_next     = w_bound_next;
                w_evt_next = 1'b1;
            end else begin
                w_next     = up ? w_inc : w_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_out <= w_next;
        r_evt <= w_evt_next;
    end

    // tc depends only on the current count, en and up; load and clear do not
    // mask it.
    assign tc  = en & w_at_bound;
    assign out = r_out;
    assign evt = r_evt;

endmodule
`default_nettype wire

// File: tb/tb_contador_updown_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_contador_updown_param
//  Description : Self-checking bench for contador_updown_param. Two instances
//                (MODULO=32/INIT_TOP=1 and MODULO=10/INIT_TOP=0) share one
//                stimulus stream and are compared every cycle against an
//                arithmetic model, plus hand-computed directed sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_contador_updown_param;

`ifdef CONTADOR_SAT_EN
    localparam bit c_sat = 1'b1;
`else
    localparam bit c_sat = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [4:0] din = '0;

    logic [4:0] out_a, out_b;
    logic       tc_a, tc_b, evt_a, evt_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic [16:0] ma = '0;   // {evt, out} expected for instance a
    logic [16:0] mb = '0;   // {evt, out} expected for instance b
    logic        m_valid = 1'b0;

    always #5 clk = ~clk;

    contador_updown_param #(.WIDTH(5), .MODULO(32), .INIT_TOP(1)) u_dut_a (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .din(din),
        .out(out_a), .tc(tc_a), .evt(evt_a)
    );

    contador_updown_param #(.WIDTH(5), .MODULO(10), .INIT_TOP(0)) u_dut_b (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .din(din),
        .out(out_b), .tc(tc_b), .evt(evt_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Next {evt,out} from the rules: priority clear > load > en, arithmetic
    // modulo m, and a boundary step either wraps or holds.
    function automatic logic [16:0] model_next(input int cur, input int m,
                                               input int init, input bit c,
                                               input bit l, input int d,
                                               input bit e, input bit u);
        int nxt;
        bit ev;
        nxt = cur;
        ev  = 1'b0;
        if (c) begin
            nxt = init;
        end else if (l) begin
            nxt = (d > m - 1) ? m - 1 : d;
        end else if (e) begin
            ev = u ? (cur == m - 1) : (cur == 0);
            if (ev && c_sat) nxt = cur;
            else             nxt = u ? (cur + 1) % m : (cur + m - 1) % m;
        end
        return {ev, nxt[15:0]};
    endfunction

    function automatic int exp_tc(input int cur, input int m, input bit e, input bit u);
        return (e && (u ? (cur == m - 1) : (cur == 0))) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        ma <= model_next(int'(ma[15:0]), 32, 31, clear, load, int'(din), en, up);
        mb <= model_next(int'(mb[15:0]), 10, 0, clear, load, int'(din), en, up);
        if (clear) m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model out_a", int'(out_a), int'(ma[15:0]));
            chk("model evt_a", int'(evt_a), int'(ma[16]));
            chk("model tc_a",  int'(tc_a),  exp_tc(int'(ma[15:0]), 32, en, up));
            chk("model out_b", int'(out_b), int'(mb[15:0]));
            chk("model evt_b", int'(evt_b), int'(mb[16]));
            chk("model tc_b",  int'(tc_b),  exp_tc(int'(mb[15:0]), 10, en, up));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int evt_cnt;
        int up_seq[4];
        int exp_seq[4];

        // Reset state
        clear = 1'b1;
        tick();
        chk("reset out_a", int'(out_a), 31);
        chk("reset evt_a", int'(evt_a), 0);
        chk("reset out_b", int'(out_b), 0);
        clear = 1'b0;

        // Count down 33 cycles from the top
        en = 1'b1; up = 1'b0; evt_cnt = 0;
        for (int i = 1; i <= 33; i++) begin
            tick();
            if (evt_a) evt_cnt++;
            if (i == 1)  chk("down first", int'(out_a), 30);
            if (i == 31) begin
                chk("down at zero", int'(out_a), 0);
                chk("tc at zero", int'(tc_a), 1);
            end
`ifndef CONTADOR_SAT_EN
            if (i == 32) begin
                chk("wrap to top", int'(out_a), 31);
                chk("wrap evt", int'(evt_a), 1);
            end
`endif
        end
`ifndef CONTADOR_SAT_EN
        chk("down evt count", evt_cnt, 1);
`else
        chk("down sat evt count", evt_cnt, 2);
        chk("down sat hold", int'(out_a), 0);
`endif
        en = 1'b0;

        // Count up 12 cycles on the modulo-10 instance
        clear = 1'b1;
        tick();
        clear = 1'b0; en = 1'b1; up = 1'b1; evt_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (evt_b) evt_cnt++;
            if (i == 9) chk("tc at nine", int'(tc_b), 1);
        end
`ifndef CONTADOR_SAT_EN
        chk("mod10 final", int'(out_b), 2);
        chk("mod10 evt count", evt_cnt, 1);
`else
        chk("mod10 sat final", int'(out_b), 9);
`endif
        en = 1'b0;

        // Load and clamp
        load = 1'b1; din = 5'd7;
        tick();
        chk("load 7 b", int'(out_b), 7);
        chk("load 7 a", int'(out_a), 7);
        din = 5'd15;
        tick();
        chk("load clamp b", int'(out_b), 9);
        chk("load 15 a", int'(out_a), 15);

        // Clear beats load and en in the same cycle
        din = 5'd5;
        tick();
        clear = 1'b1; din = 5'd3; en = 1'b1;
        tick();
        chk("clear prio out", int'(out_a), 31);
        chk("clear prio evt", int'(evt_a), 0);
        clear = 1'b0; load = 1'b0; en = 1'b0;

        // Direction toggling every cycle
        load = 1'b1; din = 5'd4;
        tick();
        load = 1'b0; en = 1'b1;
        up_seq  = '{1, 0, 1, 0};
        exp_seq = '{5, 4, 5, 4};
        for (int i = 0; i < 4; i++) begin
            up = up_seq[i][0];
            tick();
            chk("toggle out", int'(out_a), exp_seq[i]);
            chk("toggle evt", int'(evt_a), 0);
        end
        en = 1'b0;

`ifdef CONTADOR_SAT_EN
        // Saturation at the top
        load = 1'b1; din = 5'd30;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("sat out", int'(out_a), 31);
            chk("sat evt", int'(evt_a), (i == 0) ? 0 : 1);
        end
        en = 1'b0;
`endif

        // Randomised traffic, checked by the model every cycle
        for (int i = 0; i < 2000; i++) begin
            clear = ($urandom_range(0, 39) == 0);
            load  = ($urandom_range(0, 9) == 0);
            en    = ($urandom_range(0, 3) != 0);
            up    = (i % 200 < 100) ? ($urandom_range(0, 7) != 0)
                                    : ($urandom_range(0, 7) == 0);
            din   = 5'($urandom_range(0, 31));
            tick();
        end
        clear = 1'b0; load = 1'b0; en = 1'b0;
        tick();
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
